hamming_pair_encoder: RTL and testbench



---
 rtl/hamming_pair_encoder.sv | 96 +++++++++
 tb/tb_hamming_pair_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_pair_encoder.sv
// Hamming(7,4) pair encoder with per-lane single-bit error injection,
// a DEPTH-entry output FIFO and wrapping word / injected-error counters.
module hamming_pair_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       data_a,
    input  logic [3:0]       data_b,
    input  logic [2:0]       err_pos_a,
    input  logic [2:0]       err_pos_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       code_word1,
    output logic [6:0]       code_word2,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [13:0]      mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [13:0]      entry_d;
    logic             push, pop;

    // Position 1 lands in bit 6; a nonzero pos flips codeword position pos.
    function automatic logic [6:0] encode(input logic [3:0] d, input logic [2:0] pos);
        logic [6:0] cw;
        cw = {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3],
              d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
        if (pos != 3'd0)
            cw = cw ^ (7'h40 >> (pos - 3'd1));
        return cw;
    endfunction

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign code_word1 = mem_q[rd_ptr_q][13:7];
    assign code_word2 = mem_q[rd_ptr_q][6:0];
    assign word_cnt   = word_cnt_q;
    assign err_cnt    = err_cnt_q;

    always_comb begin
        entry_d    = {encode(data_a, err_pos_a), encode(data_b, err_pos_b)};
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (push) begin
            wr_ptr_d   = wr_ptr_q + PW'(1);
            word_cnt_d = word_cnt_q + CNT_W'(1);
            err_cnt_d  = err_cnt_q + CNT_W'(err_pos_a != 3'd0) + CNT_W'(err_pos_b != 3'd0);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
            if (push)
                mem_q[wr_ptr_q] <= entry_d;
        end
    end

endmodule

// File: tb/tb_hamming_pair_encoder.sv
// Bench for hamming_pair_encoder: vector table, directed FIFO corner cases,
// exhaustive encode sweep and random traffic against a queue-based model.
module tb_hamming_pair_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  data_a, data_b;
    logic [2:0]  err_pos_a, err_pos_b;
    logic [6:0]  code_word1, code_word2;
    logic [15:0] word_cnt, err_cnt;

    logic        w_in_valid, w_in_ready, w_out_valid;
    logic [6:0]  w_cw1, w_cw2;
    logic [1:0]  w_word_cnt, w_err_cnt;

    int nvec = 0;
    int nerr = 0;

    logic [13:0] q[$];
    int          wc, ec;
    bit          zero_head;

    always #5 clk = ~clk;

    hamming_pair_encoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_a(data_a), .data_b(data_b), .err_pos_a(err_pos_a), .err_pos_b(err_pos_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .code_word1(code_word1), .code_word2(code_word2),
        .word_cnt(word_cnt), .err_cnt(err_cnt)
    );

    hamming_pair_encoder #(.DEPTH(DEPTH), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .data_a(4'h5), .data_b(4'hA), .err_pos_a(3'd1), .err_pos_b(3'd6),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .code_word1(w_cw1), .code_word2(w_cw2),
        .word_cnt(w_word_cnt), .err_cnt(w_err_cnt)
    );

    // Generic Hamming construction: data sits at non-power-of-two positions,
    // parity bit p covers every position whose index has bit p set.
    function automatic logic [6:0] ref_enc(input logic [3:0] d, input int k);
        bit   p [1:7];
        int   dpos [4];
        int   pb;
        logic [6:0] r;
        dpos = '{3, 5, 6, 7};
        for (int j = 1; j <= 7; j++) p[j] = 1'b0;
        for (int i = 0; i < 4; i++) p[dpos[i]] = d[3-i];
        for (int b = 0; b < 3; b++) begin
            pb = 1 << b;
            for (int i = 0; i < 4; i++)
                if ((dpos[i] & pb) != 0) p[pb] = p[pb] ^ p[dpos[i]];
        end
        if (k != 0) p[k] = ~p[k];
        for (int j = 1; j <= 7; j++) r[7-j] = p[j];
        return r;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        cmp("in_ready", int'(in_ready), int'(q.size() != DEPTH));
        cmp("out_valid", int'(out_valid), int'(q.size() != 0));
        if (q.size() != 0) begin
            cmp("code_word1", int'(code_word1), int'(q[0][13:7]));
            cmp("code_word2", int'(code_word2), int'(q[0][6:0]));
        end else if (zero_head) begin
            cmp("code_word1_zero", int'(code_word1), 0);
            cmp("code_word2_zero", int'(code_word2), 0);
        end
        cmp("word_cnt", int'(word_cnt), wc);
        cmp("err_cnt", int'(err_cnt), ec);
    endtask

    task automatic step();
        bit mpush, mpop;
        mpush = in_valid && (q.size() < DEPTH);
        mpop  = out_ready && (q.size() != 0);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            wc = 0;
            ec = 0;
            zero_head = 1'b1;
        end else begin
            if (mpop) void'(q.pop_front());
            if (mpush) begin
                q.push_back({ref_enc(data_a, int'(err_pos_a)), ref_enc(data_b, int'(err_pos_b))});
                wc = (wc + 1) & 32'hFFFF;
                ec = (ec + int'(err_pos_a != 0) + int'(err_pos_b != 0)) & 32'hFFFF;
                zero_head = 1'b0;
            end
        end
        check_outputs();
    endtask

    task automatic set_in(input logic v, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] ea, input logic [2:0] eb);
        in_valid  = v;
        data_a    = a;
        data_b    = b;
        err_pos_a = ea;
        err_pos_b = eb;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] ea;
        logic [2:0] eb;
        logic [6:0] cw1;
        logic [6:0] cw2;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{4'b1011, 4'b0000, 3'd0, 3'd0, 7'h33, 7'h00};
        tbl[1] = '{4'b1011, 4'b1111, 3'd3, 3'd7, 7'h23, 7'h7E};
        tbl[2] = '{4'b0001, 4'b0010, 3'd0, 3'd0, 7'h69, 7'h2A};
        tbl[3] = '{4'b0100, 4'b1000, 3'd0, 3'd0, 7'h4C, 7'h70};
        tbl[4] = '{4'b1111, 4'b0000, 3'd0, 3'd1, 7'h7F, 7'h40};
        tbl[5] = '{4'b0000, 4'b0001, 3'd4, 3'd2, 7'h08, 7'h49};
        tbl[6] = '{4'b1000, 4'b0100, 3'd5, 3'd6, 7'h74, 7'h4E};
        tbl[7] = '{4'b0010, 4'b1011, 3'd1, 3'd5, 7'h6A, 7'h37};

        rst = 1'b1;
        out_ready = 1'b0;
        w_in_valid = 1'b0;
        wc = 0;
        ec = 0;
        zero_head = 1'b1;
        set_in(1'b0, 4'h0, 4'h0, 3'd0, 3'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Table vectors: push from empty, check head, then drain
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, tbl[i].a, tbl[i].b, tbl[i].ea, tbl[i].eb);
            out_ready = 1'b0;
            step();
            in_valid = 1'b0;
            cmp("tbl_cw1", int'(code_word1), int'(tbl[i].cw1));
            cmp("tbl_cw2", int'(code_word2), int'(tbl[i].cw2));
            out_ready = 1'b1;
            step();
        end

        // Fill to full with out_ready low, then a blocked fifth push
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 4'(i), 4'(i + 8), 3'd0, 3'd0);
            step();
        end
        set_in(1'b1, 4'd5, 4'd13, 3'd2, 3'd2);
        step();
        step();
        cmp("full_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cmp("drain_order", int'(code_word1), int'(ref_enc(4'(i), 0)));
            step();
            if (i == 1) cmp("ready_after_pop", int'(in_ready), 1);
        end
        out_ready = 1'b0;

        // Park at count=2, then sustained push+pop across pointer wrap
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 4'(i + 6), 4'(i), 3'd0, 3'd0);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            set_in(1'b1, 4'(i), 4'(15 - i), 3'(i % 8), 3'(7 - (i % 8)));
            step();
            cmp("steady_count", int'(q.size()), 2);
        end

        // Exhaustive nibble x err_pos sweep on both lanes
        for (int a = 0; a < 16; a++) begin
            for (int e = 0; e < 8; e++) begin
                set_in(1'b1, 4'(a), 4'(15 - a), 3'(e), 3'(7 - e));
                step();
            end
        end
        in_valid = 1'b0;
        step();
        step();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            set_in(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                   3'($urandom), 3'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end

        // Reset with 3 entries queued and a push pending
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 4'(i + 3), 4'(i + 9), 3'd1, 3'd0);
            step();
        end
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        cmp("rst_out_valid", int'(out_valid), 0);
        cmp("rst_word_cnt", int'(word_cnt), 0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();

        // Narrow-counter instance: five pushes wrap both counters
        w_in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        cmp("wrap_word_cnt", int'(w_word_cnt), 1);
        cmp("wrap_err_cnt", int'(w_err_cnt), 2);
        repeat (3) @(posedge clk);
        #1;
        cmp("wrap_word_hold", int'(w_word_cnt), 1);
        cmp("wrap_err_hold", int'(w_err_cnt), 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
